// File: rtl/ks_subtractor_pipe.sv
// Pipelined Kogge-Stone subtractor: diff = a - b - bin, evaluated as a + ~b + ~bin.
// Stage 0 forms bitwise propagate/generate. Each of the LEVELS prefix stages then
// applies one Kogge-Stone level. A final registered stage forms diff, bout, zero and ovf.
// Every stage has its own valid bit. Ready ripples back combinationally, so bubbles
// collapse and the pipe sustains one operation per cycle under backpressure.
module ks_subtractor_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);
  localparam int LEVELS = $clog2(WIDTH);
  localparam int OUT    = LEVELS + 1;

  // Stage valid bits: 0 is the p/g stage, 1..LEVELS are prefix levels, OUT is the output stage.
  logic [OUT:0]       v;
  logic [OUT:0]       adv;
  logic               rdy_chain;

  // Group propagate/generate per stage. Raw p0, carry-in and sign bits travel alongside.
  logic [WIDTH-1:0]   p_s  [0:LEVELS];
  logic [WIDTH-1:0]   g_s  [0:LEVELS];
  logic [WIDTH-1:0]   p0_s [0:LEVELS];
  logic [LEVELS:0]    c0_s;
  logic [LEVELS:0]    am_s;
  logic [LEVELS:0]    bm_s;

  logic [WIDTH-1:0]   p_nx [1:LEVELS];
  logic [WIDTH-1:0]   g_nx [1:LEVELS];
  logic [WIDTH-1:0]   gi;
  logic [WIDTH-1:0]   diff_nx;

  // Two's-complement overflow of a - b, taken from the operand and result sign bits.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

  // Backward ready chain: a stage may load when it is empty or the stage after it is moving.
  always_comb begin
    rdy_chain = out_ready;
    adv       = '0;
    for (int k = OUT; k >= 0; k--) begin
      rdy_chain = !v[k] || rdy_chain;
      adv[k]    = rdy_chain;
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = v[OUT];

  // Prefix level k combines span 2^(k-1).
  // The carry-in is folded into bit 0 before the level, so every completed group already includes it.
  always_comb begin
    gi = '0;
    for (int k = 1; k <= LEVELS; k++) begin
      gi       = g_s[k-1];
      gi[0]    = g_s[k-1][0] | (p_s[k-1][0] & c0_s[k-1]);
      p_nx[k]  = p_s[k-1];
      g_nx[k]  = gi;
      for (int i = (1 << (k-1)); i < WIDTH; i++) begin
        p_nx[k][i] = p_s[k-1][i] & p_s[k-1][i-(1 << (k-1))];
        g_nx[k][i] = gi[i] | (gi[i-(1 << (k-1))] & p_s[k-1][i]);
      end
    end
  end

  // Sum bits: bit i is its own propagate XOR the carry out of bit i-1 (the carry-in for bit 0).
  always_comb begin
    diff_nx    = '0;
    diff_nx[0] = p0_s[LEVELS][0] ^ c0_s[LEVELS];
    for (int i = 1; i < WIDTH; i++) begin
      diff_nx[i] = p0_s[LEVELS][i] ^ g_s[LEVELS][i-1];
    end
  end

  // Pipeline registers. Data loads only alongside a valid entry, so idle stages never pick up X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v    <= '0;
      c0_s <= '0;
      am_s <= '0;
      bm_s <= '0;
      for (int k = 0; k <= LEVELS; k++) begin
        p_s[k]  <= '0;
        g_s[k]  <= '0;
        p0_s[k] <= '0;
      end
      diff <= '0;
      bout <= 1'b0;
      zero <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      // ---- stage 0: bitwise propagate/generate of a + ~b, carry-in = ~bin ----
      if (adv[0]) begin
        v[0] <= in_valid;
        if (in_valid) begin
          p_s[0]  <= a ^ ~b;
          g_s[0]  <= a & ~b;
          p0_s[0] <= a ^ ~b;
          c0_s[0] <= ~bin;
          am_s[0] <= a[WIDTH-1];
          bm_s[0] <= b[WIDTH-1];
        end
      end
      // ---- stages 1..LEVELS: one Kogge-Stone prefix level each ----
      for (int k = 1; k <= LEVELS; k++) begin
        if (adv[k]) begin
          v[k] <= v[k-1];
          if (v[k-1]) begin
            p_s[k]  <= p_nx[k];
            g_s[k]  <= g_nx[k];
            p0_s[k] <= p0_s[k-1];
            c0_s[k] <= c0_s[k-1];
            am_s[k] <= am_s[k-1];
            bm_s[k] <= bm_s[k-1];
          end
        end
      end
      // ---- output stage: sum, borrow out and flags, held while stalled ----
      if (adv[OUT]) begin
        v[OUT] <= v[LEVELS];
        if (v[LEVELS]) begin
          diff <= diff_nx;
          bout <= ~g_s[LEVELS][WIDTH-1];
          zero <= (diff_nx == '0);
          ovf  <= signed_ovf(am_s[LEVELS], bm_s[LEVELS], diff_nx[WIDTH-1]);
        end
      end
    end
  end

endmodule

// File: tb/tb_ks_subtractor_pipe.sv
// Bench for ks_subtractor_pipe at WIDTH=8 and WIDTH=32.
// It uses directed vectors, a backpressure scenario, reset with operations in flight,
// and randomized handshakes checked against an arithmetic reference.
module tb_ks_subtractor_pipe;
  typedef struct packed {
    logic [31:0] diff;
    logic        bout;
    logic        zero;
    logic        ovf;
  } res_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bo;
    logic       z;
    logic       o;
  } vec_t;

  localparam int NRAND = 10000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid8, in_ready8, bin8, out_valid8, out_ready8, bout8, zero8, ovf8;
  logic [7:0]  a8, b8, diff8;
  logic        in_valid32, in_ready32, bin32, out_valid32, out_ready32, bout32, zero32, ovf32;
  logic [31:0] a32, b32, diff32;

  int total = 0;
  int bad   = 0;

  vec_t vt [10] = '{
    '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0},
    '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0},
    '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1},
    '{8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0},
    '{8'h10, 8'h10, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0},
    '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1},
    '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0},
    '{8'h00, 8'h80, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1},
    '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0},
    '{8'h01, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0}
  };

  ks_subtractor_pipe #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .bin(bin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .diff(diff8), .bout(bout8), .zero(zero8), .ovf(ovf8)
  );

  ks_subtractor_pipe #(.WIDTH(32)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a32), .b(b32), .bin(bin32), .out_valid(out_valid32), .out_ready(out_ready32),
    .diff(diff32), .bout(bout32), .zero(zero32), .ovf(ovf32)
  );

  // Reference: plain integer subtraction reduced to w bits; flags from their definitions.
  function automatic res_t model(input longint unsigned a, input longint unsigned b,
                                 input logic bin, input int w);
    longint unsigned mask, d, bl;
    res_t r;
    bl     = {63'd0, bin};
    mask   = (64'd1 << w) - 64'd1;
    d      = (a - b - bl) & mask;
    r.diff = d[31:0];
    r.bout = (a < b + bl);
    r.zero = (d == 64'd0);
    r.ovf  = (a[w-1] != b[w-1]) && (d[w-1] != a[w-1]);
    return r;
  endfunction

  // One operation into the 8-bit pipe with out_ready high; reports result and edges to out_valid.
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                         output res_t r, output int lat);
    a8 = a; b8 = b; bin8 = bin; in_valid8 = 1'b1; out_ready8 = 1'b1;
    lat = -1;
    r = '0;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (out_valid8) begin
        lat = n;
        r.diff = {24'd0, diff8};
        r.bout = bout8;
        r.zero = zero8;
        r.ovf  = ovf8;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; bin8 = 1'b0;
    in_valid32 = 1'b0; out_ready32 = 1'b1; a32 = '0; b32 = '0; bin32 = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (out_valid8 !== 1'b0 || diff8 !== 8'h00 || bout8 !== 1'b0 || zero8 !== 1'b0 || ovf8 !== 1'b0) begin
      bad++;
      $display("FAIL reset_out8: got valid=%b diff=%h bout=%b zero=%b ovf=%b, want all 0",
               out_valid8, diff8, bout8, zero8, ovf8);
    end
    total++;
    if (out_valid32 !== 1'b0 || diff32 !== 32'h0 || bout32 !== 1'b0 || zero32 !== 1'b0 || ovf32 !== 1'b0) begin
      bad++;
      $display("FAIL reset_out32: got valid=%b diff=%h bout=%b zero=%b ovf=%b, want all 0",
               out_valid32, diff32, bout32, zero32, ovf32);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready8 !== 1'b1 || in_ready32 !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: got in_ready8=%b in_ready32=%b, want 1 1", in_ready8, in_ready32);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    res_t r;
    int lat;
    for (int i = 0; i < 10; i++) begin
      run_op8(vt[i].a, vt[i].b, vt[i].bin, r, lat);
      total++;
      if (r.diff[7:0] !== vt[i].d || r.bout !== vt[i].bo || r.zero !== vt[i].z || r.ovf !== vt[i].o) begin
        bad++;
        $display("FAIL vec%0d %h-%h-%b: got diff=%h bout=%b zero=%b ovf=%b, want %h %b %b %b",
                 i, vt[i].a, vt[i].b, vt[i].bin, r.diff[7:0], r.bout, r.zero, r.ovf,
                 vt[i].d, vt[i].bo, vt[i].z, vt[i].o);
      end
      total++;
      if (lat != 5) begin
        bad++;
        $display("FAIL latency%0d: got %0d, want 5", i, lat);
      end
    end
  endtask

  // 8 ops offered back to back; consumer stalls for cycles 3..9.
  task automatic test_back_to_back();
    logic [7:0] oa [8];
    logic [7:0] ob [8];
    logic       obin [8];
    res_t exp;
    int sent = 0;
    int got  = 0;
    for (int i = 0; i < 8; i++) begin
      oa[i] = 8'($urandom); ob[i] = 8'($urandom); obin[i] = 1'($urandom);
    end
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      out_ready8 = !(cyc >= 3 && cyc <= 9);
      in_valid8  = (sent < 8);
      if (sent < 8) begin
        a8 = oa[sent]; b8 = ob[sent]; bin8 = obin[sent];
      end
      @(negedge clk);
      if (cyc >= 5 && cyc <= 9) begin
        total++;
        if (in_ready8 !== 1'b0) begin
          bad++;
          $display("FAIL full_ready cyc%0d: got in_ready=%b, want 0", cyc, in_ready8);
        end
      end
      if (cyc == 9) begin
        total++;
        if (sent != 5) begin
          bad++;
          $display("FAIL full_count: got %0d accepted, want 5", sent);
        end
      end
      if (in_valid8 && in_ready8) sent++;
      if (out_valid8 && out_ready8) begin
        exp = model(64'(oa[got]), 64'(ob[got]), obin[got], 8);
        total++;
        if (diff8 !== exp.diff[7:0] || bout8 !== exp.bout || zero8 !== exp.zero || ovf8 !== exp.ovf) begin
          bad++;
          $display("FAIL b2b_result%0d: got %h %b %b %b, want %h %b %b %b", got,
                   diff8, bout8, zero8, ovf8, exp.diff[7:0], exp.bout, exp.zero, exp.ovf);
        end
        total++;
        if (cyc != 10 + got) begin
          bad++;
          $display("FAIL b2b_cycle%0d: got cycle %0d, want %0d", got, cyc, 10 + got);
        end
        got++;
      end
      @(posedge clk); #1;
    end
    in_valid8 = 1'b0; out_ready8 = 1'b1;
    total++;
    if (got != 8) begin
      bad++;
      $display("FAIL b2b_count: got %0d results, want 8", got);
    end
  endtask

  task automatic test_reset_inflight();
    res_t r, exp;
    int lat;
    int stale = 0;
    out_ready8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom); in_valid8 = 1'b1;
      @(posedge clk); #1;
    end
    in_valid8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (out_valid8 !== 1'b1) begin
      bad++;
      $display("FAIL inflight_pre: got out_valid=%b, want 1", out_valid8);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid8 !== 1'b0 || diff8 !== 8'h00 || bout8 !== 1'b0 || zero8 !== 1'b0 || ovf8 !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got valid=%b diff=%h bout=%b zero=%b ovf=%b, want all 0",
               out_valid8, diff8, bout8, zero8, ovf8);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready8 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid8 !== 1'b0) stale++;
    end
    @(posedge clk); #1;
    total++;
    if (stale != 0) begin
      bad++;
      $display("FAIL stale_after_reset: got %0d valid cycles, want 0", stale);
    end
    run_op8(8'h3C, 8'h5A, 1'b1, r, lat);
    exp = model(64'h3C, 64'h5A, 1'b1, 8);
    total++;
    if (r.diff[7:0] !== exp.diff[7:0] || r.bout !== exp.bout || r.ovf !== exp.ovf || r.zero !== exp.zero) begin
      bad++;
      $display("FAIL post_reset_op: got %h %b %b %b, want %h %b %b %b",
               r.diff[7:0], r.bout, r.zero, r.ovf, exp.diff[7:0], exp.bout, exp.zero, exp.ovf);
    end
    total++;
    if (lat != 5) begin
      bad++;
      $display("FAIL post_reset_latency: got %0d, want 5", lat);
    end
  endtask

  task automatic test_random();
    res_t q8[$];
    res_t q32[$];
    res_t exp, hold8, hold32;
    logic held8 = 1'b0;
    logic held32 = 1'b0;
    logic take8 = 1'b1;
    logic take32 = 1'b1;
    int acc8 = 0, acc32 = 0, pop8 = 0, pop32 = 0, cyc = 0;
    in_valid8 = 1'b0; in_valid32 = 1'b0;
    while ((pop8 < NRAND || pop32 < NRAND) && cyc < 60000) begin
      if (take8 || !in_valid8) begin
        in_valid8 = (acc8 < NRAND) && ($urandom_range(3) != 0);
        a8 = 8'($urandom); bin8 = 1'($urandom);
        case ($urandom_range(5))
          0: b8 = a8;
          1: b8 = 8'h80;
          2: b8 = 8'hFF;
          default: b8 = 8'($urandom);
        endcase
      end
      if (take32 || !in_valid32) begin
        in_valid32 = (acc32 < NRAND) && ($urandom_range(3) != 0);
        a32 = $urandom; bin32 = 1'($urandom);
        case ($urandom_range(5))
          0: b32 = a32;
          1: b32 = 32'h8000_0000;
          2: b32 = 32'hFFFF_FFFF;
          default: b32 = $urandom;
        endcase
      end
      out_ready8  = ($urandom_range(3) != 0);
      out_ready32 = ($urandom_range(3) != 0);
      @(negedge clk);
      if (held8) begin
        total++;
        if (out_valid8 !== 1'b1 || diff8 !== hold8.diff[7:0] || bout8 !== hold8.bout ||
            zero8 !== hold8.zero || ovf8 !== hold8.ovf) begin
          bad++;
          $display("FAIL hold8: got valid=%b diff=%h, want 1 %h", out_valid8, diff8, hold8.diff[7:0]);
        end
      end
      if (held32) begin
        total++;
        if (out_valid32 !== 1'b1 || diff32 !== hold32.diff || bout32 !== hold32.bout ||
            zero32 !== hold32.zero || ovf32 !== hold32.ovf) begin
          bad++;
          $display("FAIL hold32: got valid=%b diff=%h, want 1 %h", out_valid32, diff32, hold32.diff);
        end
      end
      take8  = in_valid8 && in_ready8;
      take32 = in_valid32 && in_ready32;
      if (take8) begin
        q8.push_back(model(64'(a8), 64'(b8), bin8, 8));
        acc8++;
      end
      if (take32) begin
        q32.push_back(model(64'(a32), 64'(b32), bin32, 32));
        acc32++;
      end
      if (out_valid8 && out_ready8) begin
        total++;
        if (q8.size() == 0) begin
          bad++;
          $display("FAIL rand8_extra: got result %h, want none", diff8);
        end else begin
          exp = q8.pop_front();
          if (diff8 !== exp.diff[7:0] || bout8 !== exp.bout || zero8 !== exp.zero || ovf8 !== exp.ovf) begin
            bad++;
            $display("FAIL rand8 #%0d: got %h %b %b %b, want %h %b %b %b", pop8,
                     diff8, bout8, zero8, ovf8, exp.diff[7:0], exp.bout, exp.zero, exp.ovf);
          end
        end
        pop8++;
      end
      if (out_valid32 && out_ready32) begin
        total++;
        if (q32.size() == 0) begin
          bad++;
          $display("FAIL rand32_extra: got result %h, want none", diff32);
        end else begin
          exp = q32.pop_front();
          if (diff32 !== exp.diff || bout32 !== exp.bout || zero32 !== exp.zero || ovf32 !== exp.ovf) begin
            bad++;
            $display("FAIL rand32 #%0d: got %h %b %b %b, want %h %b %b %b", pop32,
                     diff32, bout32, zero32, ovf32, exp.diff, exp.bout, exp.zero, exp.ovf);
          end
        end
        pop32++;
      end
      held8  = out_valid8 && !out_ready8;
      hold8  = {24'd0, diff8, bout8, zero8, ovf8};
      held32 = out_valid32 && !out_ready32;
      hold32 = {diff32, bout32, zero32, ovf32};
      @(posedge clk); #1;
      cyc++;
    end
    in_valid8 = 1'b0; in_valid32 = 1'b0;
    total++;
    if (pop8 != NRAND || q8.size() != 0) begin
      bad++;
      $display("FAIL rand8_drain: got %0d results (%0d queued), want %0d", pop8, q8.size(), NRAND);
    end
    total++;
    if (pop32 != NRAND || q32.size() != 0) begin
      bad++;
      $display("FAIL rand32_drain: got %0d results (%0d queued), want %0d", pop32, q32.size(), NRAND);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_inflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
